data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Shares the single-port DataMemory between two requesters: the processor's load/store path (CPU port) and an external loader/IO engine (DMA port). It accepts byte-addressed requests, translates them to word indices, checks range and alignment, and sequences each access through a three-state FSM with round-robin arbitration. Its memory-side outputs connect to the DataMemory port. Its CPU-side ack serves as the processor's memory stall/release signal.

## Interface
- DATA_BASE, 32'h10010000, byte address mapped to word 0 of DataMemory
- MEMORY_DEPTH, 1024, number of 32-bit words in DataMemory
- ADDR_WIDTH, 10, width of mem_address (clog2(MEMORY_DEPTH))

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  1 = store, 0 = load; held with cpu_req
- cpu_addr  input  32  CPU byte address; held with cpu_req
- cpu_wdata  input  32  CPU store data; held with cpu_req
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  32  load data, valid while cpu_ack=1
- cpu_err  output  1  access rejected, valid while cpu_ack=1
- dma_req, dma_we, dma_addr, dma_wdata  input  1/1/32/32  same semantics as CPU port
- dma_ack, dma_rdata, dma_err  output  1/32/1  same semantics as CPU port
- mem_address  output  ADDR_WIDTH  word index to DataMemory
- mem_wdata  output  32  write data to DataMemory
- mem_write  output  1  DataMemory write enable
- mem_read  output  1  DataMemory read enable
- mem_rdata  input  32  DataMemory read data (combinational from mem_address)
- busy  output  1  high whenever state != IDLE

## Operation
- FSM states are IDLE, ACCESS and DONE.
- In IDLE:
  - If either req is high, the arbiter selects one owner and moves to ACCESS.
  - Both high: the requester not granted last wins.
  - last_grant resets to DMA, so CPU wins the first tie.
- Address check, computed from the owner's address: off = addr - DATA_BASE (32-bit, wrap-around).
  - Error if off[1:0] != 0.
  - Error if off[31:2] >= MEMORY_DEPTH. A wrapped (below-base) address yields a huge off and therefore errors.
  - The check is registered on grant.
- In ACCESS, with no error:
  - mem_address = off[ADDR_WIDTH+1:2].
  - mem_wdata = owner wdata.
  - mem_write = owner we; mem_read = !owner we.
- In ACCESS, with error: mem_write=0 and mem_read=0; memory is untouched.
- At the end of ACCESS:
  - rdata is registered from mem_rdata for a good load, otherwise 0.
  - err is registered.
  - last_grant is updated to the owner.
  - The FSM moves to DONE.
- In DONE:
  - The owner's ack=1. Its rdata and err are valid.
  - The other port's ack=0, rdata=0, err=0.
  - The FSM moves unconditionally to IDLE.
- Requesters must drop req at the edge that ends the ack cycle. A req still high in IDLE is treated as a new request.
- Request signals change while req is high and before ack: the result is undefined; the bench flags it as a protocol violation.

## Timing
- Reset (asynchronous assert, any state):
  - State goes to IDLE and last_grant goes to DMA.
  - All acks, errs, rdatas, mem_write, mem_read and mem_address return to 0, and busy goes to 0.
  - An in-flight write is aborted with no memory update.
  - No ack is ever issued for an aborted request.
- Latency: req first high in cycle 0 (IDLE) gives ACCESS in cycle 1 and ack in cycle 2. This is 2 cycles from req to ack.
- Store commit: the memory write occurs at the rising edge ending cycle 1.
- Throughput: one access per 3 cycles. Two continuously requesting ports alternate CPU, DMA, CPU, ...
- A request arriving during ACCESS or DONE waits; it is sampled in the next IDLE cycle.
- mem_* outputs are driven only in ACCESS and are 0 in IDLE and DONE.
- All outputs are registered or decoded from registered state; there is no combinational req-to-mem path.

## Test plan
- Reset then CPU store: cpu_addr=0x10010008, cpu_wdata=0xDEADBEEF, cpu_we=1 -> mem_write=1 with mem_address=2 in cycle 1, cpu_ack in cycle 2, cpu_err=0. A following load of the same address returns 0xDEADBEEF.
- Simultaneous req on both ports (CPU load 0x10010008, DMA load 0x1001000C) held continuously -> CPU acked first, DMA three cycles later. Ack order then alternates CPU/DMA, and dma_ack is never high with cpu_ack.
- Misaligned 0x10010006 and out-of-range 0x10011000 (word 1024) and below-base 0x1000FFFC -> ack with err=1 and rdata=0 each time. mem_write and mem_read stay 0, and the memory contents are unchanged.
- Boundary: DMA store to 0x10010FFC (word 1023) -> succeeds, err=0, mem_address=1023.
- Reset asserted during ACCESS of a store to word 5 -> no ack follows, word 5 keeps its old value, and all outputs are 0 immediately. After release, the first tie is won by CPU.
- Request arriving during DONE of the other port -> granted in the following IDLE, acked 2 cycles later, busy high throughout except the single IDLE cycle.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of the single-port DataMemory.
// Each access runs IDLE -> ACCESS -> DONE with round-robin tie-breaking.
module data_memory_arbiter #(
    parameter logic [31:0] DATA_BASE    = 32'h10010000,
    parameter int          MEMORY_DEPTH = 1024,
    parameter int          ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ack,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_err,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [31:0]           dma_addr,
    input  logic [31:0]           dma_wdata,
    output logic                  dma_ack,
    output logic [31:0]           dma_rdata,
    output logic                  dma_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    localparam logic [29:0] DEPTH_WORDS = 30'(MEMORY_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

    stateT                 state, nextState;
    logic                  ownerDma, lastGrantDma, ownerWe, accErr, resErr;
    logic [ADDR_WIDTH-1:0] ownerWord;
    logic [31:0]           ownerWdata, resRdata;

    logic                  anyReq, grantDma, selErr;
    logic [31:0]           selAddr, offset;
    logic                  memGo;

    // Tie goes to whichever port was not served last.
    always_comb begin
        anyReq   = cpu_req || dma_req;
        grantDma = dma_req && (!cpu_req || !lastGrantDma);
        selAddr  = grantDma ? dma_addr : cpu_addr;
        offset   = selAddr - DATA_BASE;
        selErr   = (offset[1:0] != 2'b00) || (offset[31:2] >= DEPTH_WORDS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (anyReq) nextState = ACCESS;
            ACCESS:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Owner request is latched on grant so the memory side never sees live inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ownerDma     <= 1'b0;
            lastGrantDma <= 1'b1;
            ownerWe      <= 1'b0;
            accErr       <= 1'b0;
            resErr       <= 1'b0;
            ownerWord    <= '0;
            ownerWdata   <= '0;
            resRdata     <= '0;
        end else begin
            if (state == IDLE && anyReq) begin
                ownerDma   <= grantDma;
                ownerWe    <= grantDma ? dma_we : cpu_we;
                ownerWdata <= grantDma ? dma_wdata : cpu_wdata;
                ownerWord  <= offset[ADDR_WIDTH+1:2];
                accErr     <= selErr;
            end
            if (state == ACCESS) begin
                resRdata     <= (!accErr && !ownerWe) ? mem_rdata : '0;
                resErr       <= accErr;
                lastGrantDma <= ownerDma;
            end
        end
    end

    always_comb begin
        memGo       = (state == ACCESS) && !accErr;
        mem_write   = memGo && ownerWe;
        mem_read    = memGo && !ownerWe;
        mem_address = memGo ? ownerWord : '0;
        mem_wdata   = (memGo && ownerWe) ? ownerWdata : '0;
        busy        = (state != IDLE);
        cpu_ack     = (state == DONE) && !ownerDma;
        dma_ack     = (state == DONE) && ownerDma;
        cpu_rdata   = cpu_ack ? resRdata : '0;
        cpu_err     = cpu_ack && resErr;
        dma_rdata   = dma_ack ? resRdata : '0;
        dma_err     = dma_ack && resErr;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table, timing corner cases and
// randomized traffic checked against an address-rule / memory-image model.
module tb_data_memory_arbiter;

    localparam logic [31:0] BASE = 32'h10010000;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [9:0]  mem_address;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;

    logic [31:0] tbMem  [0:1023];
    logic [31:0] refMem [0:1023];
    logic        loadMem = 1'b0;

    int checks = 0;
    int failures = 0;

    data_memory_arbiter dut (
        .clk(clk), .reset(resetN),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
    endfunction

    // DataMemory stand-in: combinational read, write on rising edge.
    assign mem_rdata = tbMem[mem_address];
    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 1024; i++) tbMem[i] <= initVal(i);
        end else if (mem_write) begin
            tbMem[mem_address] <= mem_wdata;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drivePort(input bit isDma, input bit req, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (isDma) begin
            dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // One single-port access, starting from IDLE with expectations supplied by the caller.
    task automatic doTxn(input string tag, input bit isDma, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit expErr, input logic [31:0] expRdata, input logic [9:0] expWord);
        int cyc;
        bit got, otherAck, sawWr, sawRd;
        logic [9:0]  sawAddr;
        logic [31:0] sawWdata, gotRdata, othRdata;
        logic        gotErr, othErr;
        @(posedge clk); #1;
        drivePort(isDma, 1'b1, we, addr, wdata);
        cyc = 0; got = 0; otherAck = 0;
        sawWr = 0; sawRd = 0; sawAddr = '0; sawWdata = '0;
        gotRdata = '0; gotErr = 0; othRdata = '0; othErr = 0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            if (cyc == 1) begin
                sawWr = mem_write; sawRd = mem_read; sawAddr = mem_address; sawWdata = mem_wdata;
            end
            if (isDma ? cpu_ack : dma_ack) otherAck = 1;
            if (isDma ? dma_ack : cpu_ack) begin
                got = 1;
                gotRdata = isDma ? dma_rdata : cpu_rdata;
                gotErr   = isDma ? dma_err : cpu_err;
                othRdata = isDma ? cpu_rdata : dma_rdata;
                othErr   = isDma ? cpu_err : dma_err;
            end else begin
                cyc++;
            end
        end
        check($sformatf("%s latency", tag), 32'(cyc), 32'd2);
        check($sformatf("%s err", tag), 32'(gotErr), 32'(expErr));
        check($sformatf("%s rdata", tag), gotRdata, expRdata);
        check($sformatf("%s other port quiet", tag), {othRdata[30:0], othErr ^ otherAck}, 32'd0);
        check($sformatf("%s mem_write", tag), 32'(sawWr), 32'(!expErr && we));
        check($sformatf("%s mem_read", tag), 32'(sawRd), 32'(!expErr && !we));
        if (!expErr) check($sformatf("%s mem_address", tag), 32'(sawAddr), 32'(expWord));
        if (!expErr && we) check($sformatf("%s mem_wdata", tag), sawWdata, wdata);
        @(posedge clk); #1;
        drivePort(isDma, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    typedef struct {
        bit          isDma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          expErr;
        logic [31:0] expRdata;
        logic [9:0]  expWord;
    } vecT;

    vecT vecs [12];

    initial begin
        int mism;
        bit cAck, dAck;
        logic [31:0] expRd;

        for (int i = 0; i < 1024; i++) refMem[i] = initVal(i);
        vecs[0]  = '{0, 1, 32'h10010008, 32'hDEADBEEF, 0, 32'h0,        10'd2};
        vecs[1]  = '{0, 0, 32'h10010008, 32'h0,        0, 32'hDEADBEEF, 10'd2};
        vecs[2]  = '{0, 0, 32'h10010006, 32'h0,        1, 32'h0,        10'd0};
        vecs[3]  = '{0, 1, 32'h10011000, 32'h11111111, 1, 32'h0,        10'd0};
        vecs[4]  = '{1, 1, 32'h1000FFFC, 32'h22222222, 1, 32'h0,        10'd0};
        vecs[5]  = '{1, 0, 32'h10011000, 32'h0,        1, 32'h0,        10'd0};
        vecs[6]  = '{1, 1, 32'h10010FFC, 32'h12345678, 0, 32'h0,        10'd1023};
        vecs[7]  = '{1, 0, 32'h10010FFC, 32'h0,        0, 32'h12345678, 10'd1023};
        vecs[8]  = '{0, 0, 32'h10010000, 32'h0,        0, initVal(0),   10'd0};
        vecs[9]  = '{1, 0, 32'h10010008, 32'h0,        0, 32'hDEADBEEF, 10'd2};
        vecs[10] = '{0, 1, 32'h10010003, 32'h33333333, 1, 32'h0,        10'd0};
        vecs[11] = '{1, 0, 32'h1001000C, 32'h0,        0, initVal(3),   10'd3};

        // Reset state
        loadMem = 1'b1;
        repeat (2) @(posedge clk);
        #1 loadMem = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        check("reset errs", {30'd0, cpu_err, dma_err}, 32'd0);
        check("reset rdata", cpu_rdata | dma_rdata, 32'd0);
        check("reset mem strobes", {30'd0, mem_write, mem_read}, 32'd0);
        check("reset mem_address", 32'(mem_address), 32'd0);
        @(posedge clk); #1 resetN = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            doTxn($sformatf("vec%0d", i), vecs[i].isDma, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].expErr, vecs[i].expRdata, vecs[i].expWord);
            if (!vecs[i].expErr && vecs[i].we) refMem[vecs[i].expWord] = vecs[i].wdata;
        end

        // Both ports held: CPU first (DMA served last), then strict alternation every 3 cycles
        @(posedge clk); #1;
        drivePort(0, 1, 0, 32'h10010008, 0);
        drivePort(1, 1, 0, 32'h1001000C, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cAck = (i % 6 == 2);
            dAck = (i % 6 == 5);
            check($sformatf("tie cyc%0d cpu_ack", i), 32'(cpu_ack), 32'(cAck));
            check($sformatf("tie cyc%0d dma_ack", i), 32'(dma_ack), 32'(dAck));
            if (cAck) check($sformatf("tie cyc%0d cpu_rdata", i), cpu_rdata, refMem[2]);
            if (dAck) check($sformatf("tie cyc%0d dma_rdata", i), dma_rdata, refMem[3]);
        end
        @(posedge clk); #1;
        drivePort(0, 0, 0, 0, 0);
        drivePort(1, 0, 0, 0, 0);

        // DMA request arriving during the CPU's DONE cycle
        @(posedge clk); #1;
        drivePort(0, 1, 0, 32'h10010000, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("late cyc%0d busy", i), 32'(busy), 32'(i == 1 || i == 2 || i == 4 || i == 5));
            check($sformatf("late cyc%0d cpu_ack", i), 32'(cpu_ack), 32'(i == 2));
            check($sformatf("late cyc%0d dma_ack", i), 32'(dma_ack), 32'(i == 5));
            if (i == 2) begin
                #1 drivePort(1, 1, 0, 32'h10010FFC, 0);
            end
            if (i == 3) drivePort(0, 0, 0, 0, 0);
            if (i == 5) begin
                check("late dma_rdata", dma_rdata, refMem[1023]);
                #1 drivePort(1, 0, 0, 0, 0);
            end
        end

        // Reset during ACCESS of a store to word 5, after a CPU grant
        doTxn("pre-abort", 0, 0, 32'h10010010, 0, 0, refMem[4], 10'd4);
        @(posedge clk); #1;
        drivePort(0, 1, 1, 32'h10010014, 32'hBADC0DE5);
        @(negedge clk);
        @(negedge clk);
        check("abort access mem_write", 32'(mem_write), 32'd1);
        check("abort access mem_address", 32'(mem_address), 32'd5);
        #2 resetN = 1'b0;
        #1;
        check("abort outputs", {28'd0, busy, mem_write, mem_read, cpu_ack}, 32'd0);
        check("abort mem_address", 32'(mem_address), 32'd0);
        drivePort(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort hold%0d ack", i), {30'd0, cpu_ack, dma_ack}, 32'd0);
        end
        @(posedge clk); #1 resetN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("abort post%0d ack", i), {30'd0, cpu_ack, dma_ack}, 32'd0);
        end
        check("abort word5 kept", tbMem[5], refMem[5]);
        @(posedge clk); #1;
        drivePort(0, 1, 0, 32'h10010014, 0);
        drivePort(1, 1, 0, 32'h10010008, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post-reset tie cyc%0d cpu_ack", i), 32'(cpu_ack), 32'(i == 2));
            check($sformatf("post-reset tie cyc%0d dma_ack", i), 32'(dma_ack), 32'(i == 5));
            if (i == 2) begin
                check("post-reset cpu_rdata", cpu_rdata, refMem[5]);
                #1 drivePort(0, 0, 0, 0, 0);
            end
            if (i == 5) begin
                check("post-reset dma_rdata", dma_rdata, refMem[2]);
                #1 drivePort(1, 0, 0, 0, 0);
            end
        end

        // Randomized single-port traffic against the address-rule model
        for (int n = 0; n < 60; n++) begin
            bit          isDma, we, expErr;
            int          cat;
            logic [31:0] addr, wdata, off;
            logic [9:0]  word;
            isDma = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            cat   = $urandom_range(0, 6);
            if (cat <= 3)      addr = BASE + 4 * $urandom_range(0, 1023);
            else if (cat == 4) addr = BASE + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
            else if (cat == 5) addr = BASE + 4 * (1024 + $urandom_range(0, 5000));
            else               addr = BASE - 4 * $urandom_range(1, 100);
            off    = addr - BASE;
            expErr = (off % 4 != 0) || (off / 4 >= 1024);
            word   = expErr ? 10'd0 : 10'(off / 4);
            expRd  = (!expErr && !we) ? refMem[word] : 32'd0;
            doTxn($sformatf("rnd%0d", n), isDma, we, addr, wdata, expErr, expRd, word);
            if (!expErr && we) refMem[word] = wdata;
        end

        // Whole memory image must match the model
        @(posedge clk);
        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (tbMem[i] !== refMem[i]) mism++;
        check("memory image mismatching words", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
